// File: rtl/hv_wdg_reg_scan_if.sv
// Read port between the background register scanner (master) and the register access arbiter (slave).
// The master holds rd_req/addr until a single-cycle ack, which carries data and stored CRC in the same cycle.
interface hv_wdg_reg_scan_if #(
    parameter int AW = 7,
    parameter int DW = 8,
    parameter int CW = 8
) ();
    logic          wdg_scan_rac_rd_req;
    logic [AW-1:0] wdg_scan_rac_addr;
    logic          rac_wdg_scan_ack;
    logic [DW-1:0] rac_wdg_scan_data;
    logic [CW-1:0] rac_wdg_scan_crc;

    modport master (
        output wdg_scan_rac_rd_req,
        output wdg_scan_rac_addr,
        input  rac_wdg_scan_ack,
        input  rac_wdg_scan_data,
        input  rac_wdg_scan_crc
    );

    modport slave (
        input  wdg_scan_rac_rd_req,
        input  wdg_scan_rac_addr,
        output rac_wdg_scan_ack,
        output rac_wdg_scan_data,
        output rac_wdg_scan_crc
    );
endinterface

// File: rtl/hv_wdg_reg_scan.sv
// Background register CRC scanner; the optional saturating error counter is enabled by WDG_SCAN_ERR_CNT_EN.
// Latency: req at t, ack at t+2 gives req low at t+3, crc_err/done at t+4, next req at t+4+SCAN_GAP.
// Backpressure: the request is held until ack or ACK_TO req-high cycles; acks outside REQ are ignored.
module hv_wdg_reg_scan #(
    parameter int                REG_AW          = 7,
    parameter int                REG_DW          = 8,
    parameter int                REG_CRC_W       = 8,
    parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
    parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
    parameter int                SCAN_GAP        = 16,
    parameter int                ACK_TO          = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scan_en,
    hv_wdg_reg_scan_if.master     rac,
    output logic                  o_scan_busy,
    output logic                  o_scan_crc_err,
    output logic                  o_scan_timeout,
    output logic [REG_AW-1:0]     o_scan_err_addr,
    output logic                  o_scan_done,
    input  logic                  i_scan_err_clr,
    output logic [7:0]            o_scan_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CHECK = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int                   TO_W     = $clog2(ACK_TO + 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(ACK_TO - 1);
    localparam int                   GAP_W    = $clog2(SCAN_GAP + 2);
    localparam logic [GAP_W-1:0]     GAP_LAST = (SCAN_GAP > 0) ? GAP_W'(SCAN_GAP - 1) : '0;
    localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(8'h07);

    // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final xor.
    function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [REG_DW-1:0] d);
        logic [REG_CRC_W-1:0] c;
        c = '0;
        for (int i = REG_DW - 1; i >= 0; i--) begin
            if (c[REG_CRC_W-1] ^ d[i]) begin
                c = {c[REG_CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[REG_CRC_W-2:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    state_t                 post_txn;
    logic                   req_q;
    logic [REG_AW-1:0]      addr_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [REG_DW-1:0]      cap_data_q;
    logic [REG_CRC_W-1:0]   cap_crc_q;
    logic                   crc_err_q;
    logic                   timeout_q;
    logic                   done_q;
    logic [REG_AW-1:0]      err_addr_q;

    logic                   busy;
    logic                   ack_take;
    logic                   to_evt;
    logic                   crc_bad;
    logic                   advance;
    logic                   at_end;
    logic                   to_hit;
    logic                   gap_hit;

    assign to_hit  = (to_cnt_q == TO_LAST);
    assign gap_hit = (gap_cnt_q == GAP_LAST);
    assign at_end  = (addr_q == SCAN_END_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        post_txn = ST_GAP;
        if (SCAN_GAP == 0) begin
            post_txn = i_scan_en ? ST_REQ : ST_IDLE;
        end
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_scan_en) state_d = ST_REQ;
            ST_REQ: begin
                if (rac.rac_wdg_scan_ack) begin
                    state_d = ST_CHECK;
                end else if (to_hit) begin
                    state_d = post_txn;
                end
            end
            ST_CHECK: state_d = post_txn;
            ST_GAP:   if (gap_hit) state_d = i_scan_en ? ST_REQ : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        busy     = (state_q != ST_IDLE);
        ack_take = (state_q == ST_REQ) && rac.rac_wdg_scan_ack;
        to_evt   = (state_q == ST_REQ) && !rac.rac_wdg_scan_ack && to_hit;
        crc_bad  = (state_q == ST_CHECK) && (crc_calc(cap_data_q) != cap_crc_q);
        advance  = to_evt || (state_q == ST_CHECK);
    end

    // Timers only run in their own state and restart from zero on every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            to_cnt_q  <= (state_q == ST_REQ) ? to_cnt_q + TO_W'(1)   : '0;
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GAP_W'(1) : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q      <= 1'b0;
            addr_q     <= SCAN_START_ADDR;
            cap_data_q <= '0;
            cap_crc_q  <= '0;
            crc_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            err_addr_q <= '0;
        end else begin
            req_q     <= (state_d == ST_REQ);
            crc_err_q <= crc_bad;
            timeout_q <= to_evt;
            done_q    <= advance && at_end;
            if (ack_take) begin
                cap_data_q <= rac.rac_wdg_scan_data;
                cap_crc_q  <= rac.rac_wdg_scan_crc;
            end
            if (crc_bad || to_evt) begin
                err_addr_q <= addr_q;
            end
            // Inclusive window: wrap on the end address, so addr+1 never overflows.
            if (advance) begin
                addr_q <= at_end ? SCAN_START_ADDR : addr_q + 1'b1;
            end
        end
    end

`ifdef WDG_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts the visible pulses; a clear in the same cycle as a pulse wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (i_scan_err_clr) begin
            err_cnt_q <= 8'h00;
        end else if ((crc_err_q || timeout_q) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign o_scan_err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_scan_err_clr;
    assign o_scan_err_cnt = 8'h00;
`endif

    assign rac.wdg_scan_rac_rd_req = req_q;
    assign rac.wdg_scan_rac_addr   = addr_q;
    assign o_scan_busy             = busy;
    assign o_scan_crc_err          = crc_err_q;
    assign o_scan_timeout          = timeout_q;
    assign o_scan_err_addr         = err_addr_q;
    assign o_scan_done             = done_q;

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Scoreboard bench for hv_wdg_reg_scan: window 0x10..0x12, gap 2, ack timeout 8.
// Stimulus pushes expected events; a negedge monitor pops them as the DUT presents req/crc_err/timeout/done.
module tb_hv_wdg_reg_scan;
    localparam logic [6:0] START = 7'h10;
    localparam logic [6:0] END_A = 7'h12;
    localparam int K_REQ = 0, K_CRC = 1, K_TO = 2, K_DONE = 3;
`ifdef WDG_SCAN_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed { logic [1:0] kind; logic [6:0] addr; } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_en = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy, crc_err, timeout, done;
    logic [6:0] err_addr;
    logic [7:0] err_cnt;

    hv_wdg_reg_scan_if #(.AW(7), .DW(8), .CW(8)) rac ();

    hv_wdg_reg_scan #(
        .REG_AW(7), .REG_DW(8), .REG_CRC_W(8),
        .SCAN_START_ADDR(START), .SCAN_END_ADDR(END_A),
        .SCAN_GAP(2), .ACK_TO(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .rac(rac),
        .o_scan_busy(busy), .o_scan_crc_err(crc_err), .o_scan_timeout(timeout),
        .o_scan_err_addr(err_addr), .o_scan_done(done),
        .i_scan_err_clr(err_clr), .o_scan_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    logic [7:0] dly_tab [128];
    logic [7:0] dat_tab [128];
    logic [7:0] crc_tab [128];
    bit         bad_tab [128];
    logic [6:0] ptr = START;
    bit   inj_ack = 1'b0;
    bit   clr_on_err = 1'b0;
    int   rise_cyc = 0, prev_rise = 0, last_hi_len = 0, hi_max = 0, last_err_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [6:0] a);
        ev_t e;
        e.kind = kind[1:0];
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [6:0] a);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h, expected none", kind, a);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, int'(e.kind));
            check("event_addr", int'(a), int'(e.addr));
        end
    endtask

    task automatic set_rsp(input logic [6:0] a, input logic [7:0] dly,
                           input logic [7:0] d, input logic [7:0] c, input bit bad);
        dly_tab[a] = dly;
        dat_tab[a] = d;
        crc_tab[a] = c;
        bad_tab[a] = bad;
    endtask

    // Arbiter model: acks dly_tab[addr] cycles after req rises; can also inject a stray ack.
    initial begin
        bit         pend;
        bit         prev_req;
        int         n;
        logic [6:0] a;
        pend = 1'b0; prev_req = 1'b0; n = 0; a = '0;
        rac.rac_wdg_scan_ack  = 1'b0;
        rac.rac_wdg_scan_data = 8'h00;
        rac.rac_wdg_scan_crc  = 8'h00;
        forever begin
            @(negedge clk);
            rac.rac_wdg_scan_ack = 1'b0;
            err_clr = clr_on_err && crc_err;
            if (!rst_n) begin
                pend = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (rac.wdg_scan_rac_rd_req && !prev_req) begin
                    pend = 1'b1; n = 0; a = rac.wdg_scan_rac_addr;
                end else if (pend) begin
                    n++;
                end
                if (!rac.wdg_scan_rac_rd_req) pend = 1'b0;
                if (pend && n == int'(dly_tab[a])) begin
                    rac.rac_wdg_scan_ack  = 1'b1;
                    rac.rac_wdg_scan_data = dat_tab[a];
                    rac.rac_wdg_scan_crc  = crc_tab[a];
                    pend = 1'b0;
                end else if (inj_ack) begin
                    rac.rac_wdg_scan_ack  = 1'b1;
                    rac.rac_wdg_scan_data = 8'hFF;
                    rac.rac_wdg_scan_crc  = 8'h00;
                    inj_ack = 1'b0;
                end
                prev_req = rac.wdg_scan_rac_rd_req;
            end
        end
    end

    // Monitor: pops the scoreboard in the fixed order timeout, crc_err, done, req-rise.
    initial begin
        bit prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (timeout) begin
                    last_err_lat = cyc - rise_cyc;
                    expect_ev(K_TO, err_addr);
                end
                if (crc_err) begin
                    last_err_lat = cyc - rise_cyc;
                    expect_ev(K_CRC, err_addr);
                end
                if (done) expect_ev(K_DONE, rac.wdg_scan_rac_addr);
                if (rac.wdg_scan_rac_rd_req && !prev_req) begin
                    prev_rise = rise_cyc;
                    rise_cyc  = cyc;
                    expect_ev(K_REQ, rac.wdg_scan_rac_addr);
                end
                if (!rac.wdg_scan_rac_rd_req && prev_req) begin
                    last_hi_len = cyc - rise_cyc;
                    if (last_hi_len > hi_max) hi_max = last_hi_len;
                end
                prev_req = rac.wdg_scan_rac_rd_req;
            end
        end
    end

    // Queue the expected events of n transactions, enable, drop en during the last request, wait for IDLE.
    task automatic run_txns(input int n);
        int trail;
        int budget;
        trail = 0;
        for (int i = 0; i < n; i++) begin
            push(K_REQ, ptr);
            trail = 0;
            if (dly_tab[ptr] == 8'hFF) begin
                push(K_TO, ptr); trail++;
            end else if (bad_tab[ptr]) begin
                push(K_CRC, ptr); trail++;
            end
            if (ptr == END_A) begin
                push(K_DONE, START); trail++;
                ptr = START;
            end else begin
                ptr = ptr + 7'd1;
            end
        end
        @(negedge clk);
        scan_en = 1'b1;
        budget = n * 20 + 40;
        while (exp_q.size() > trail && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        scan_en = 1'b0;
        check("last_req_reached", int'(exp_q.size() <= trail), 1);
        budget = 60;
        while ((busy || exp_q.size() != 0) && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        check("idle_busy", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        for (int i = 0; i < 128; i++) set_rsp(i[6:0], 8'd2, 8'h01, 8'h07, 1'b0);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", int'(rac.wdg_scan_rac_rd_req), 0);
        check("rst_addr", int'(rac.wdg_scan_rac_addr), 'h10);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({crc_err, timeout, done}), 0);
        check("rst_err_addr", int'(err_addr), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean pass 10,11,12 (done), then 10 again
        run_txns(4);
        check("s1_req_high_len", last_hi_len, 3);
        check("s1_req_period", rise_cyc - prev_rise, 6);

        // 1b: other clean vectors 0xFF/0xF3 and 0x00/0x00
        set_rsp(7'h11, 8'd2, 8'hFF, 8'hF3, 1'b0);
        set_rsp(7'h12, 8'd2, 8'h00, 8'h00, 1'b0);
        run_txns(3);
        set_rsp(7'h12, 8'd2, 8'h01, 8'h07, 1'b0);

        // 2: CRC mismatch on addr 11
        set_rsp(7'h11, 8'd2, 8'hFF, 8'hF2, 1'b1);
        run_txns(3);
        check("s2_err_latency", last_err_lat, 4);
        check("s2_err_addr_hold", int'(err_addr), 'h11);
        set_rsp(7'h11, 8'd2, 8'h01, 8'h07, 1'b0);

        // 3: addr 10 never acked
        set_rsp(7'h10, 8'hFF, 8'h01, 8'h07, 1'b0);
        hi_max = 0;
        run_txns(4);
        check("s3_timeout_req_len", hi_max, 8);
        check("s3_timeout_latency", last_err_lat, 8);
        check("s3_err_addr", int'(err_addr), 'h10);
        set_rsp(7'h10, 8'd2, 8'h01, 8'h07, 1'b0);

        // 4: en dropped with req high, ack 3 cycles later carries a bad CRC
        set_rsp(7'h12, 8'd3, 8'h01, 8'h00, 1'b1);
        run_txns(1);
        check("s4_req_high_len", last_hi_len, 4);
        check("s4_idle_req", int'(rac.wdg_scan_rac_rd_req), 0);
        set_rsp(7'h12, 8'd2, 8'h01, 8'h07, 1'b0);
        inj_ack = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("s4_stray_ack_busy", int'(busy), 0);
        run_txns(1);

        // 5: reset one cycle after req rises, then a stray ack
        set_rsp(7'h11, 8'd4, 8'hFF, 8'h00, 1'b1);
        push(K_REQ, ptr);
        @(negedge clk);
        scan_en = 1'b1;
        budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        check("s5_req_seen", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        scan_en = 1'b0;
        #1;
        check("s5_rst_req", int'(rac.wdg_scan_rac_rd_req), 0);
        check("s5_rst_addr", int'(rac.wdg_scan_rac_addr), 'h10);
        check("s5_rst_busy", int'(busy), 0);
        check("s5_rst_pulses", int'({crc_err, timeout, done}), 0);
        check("s5_rst_err_addr", int'(err_addr), 0);
        ptr = START;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        inj_ack = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("s5_post_ack_busy", int'(busy), 0);
        check("s5_post_ack_addr", int'(rac.wdg_scan_rac_addr), 'h10);
        set_rsp(7'h11, 8'd2, 8'h01, 8'h07, 1'b0);
        run_txns(1);

        // 6: 300 forced errors, then clear coinciding with an error, then one more error
        for (int i = 0; i < 128; i++) set_rsp(i[6:0], 8'd2, 8'h01, 8'h00, 1'b1);
        run_txns(300);
        check("s6_err_cnt_sat", int'(err_cnt), CNT_EN ? 'hFF : 0);
        clr_on_err = 1'b1;
        run_txns(1);
        clr_on_err = 1'b0;
        check("s6_err_cnt_clr_wins", int'(err_cnt), 0);
        run_txns(1);
        check("s6_err_cnt_after_clr", int'(err_cnt), CNT_EN ? 1 : 0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
